memory_turn_ctrl: RTL and testbench

Turn sequencer for the 16-card memory game. It takes card selections from the cursor/selection datapath and the 16 card values it exposes. It enforces two-player turn order, flips and un-flips cards, detects pairs, keeps score and runs a per-turn timeout. It drives the face-up/matched masks consumed by the display logic and reports the winner when all 8 pairs are found.

---
 rtl/memgame_pkg.sv | 33 +++
 rtl/turn_timer.sv | 28 ++
 rtl/memory_turn_ctrl.sv | 207 ++++++++++++++++++++
 tb/tb_memory_turn_ctrl.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/memgame_pkg.sv
// Shared types and constants for the memory-game turn sequencer.
package memgame_pkg;

    localparam int unsigned NUM_CARDS = 16;
    localparam int unsigned NUM_PAIRS = 8;

    typedef enum logic [3:0] {
        IDLE    = 4'd0,
        FIRST   = 4'd1,
        SECOND  = 4'd2,
        COMPARE = 4'd3,
        SHOW    = 4'd4,
        DONE    = 4'd5
    } state_t;

    localparam logic [1:0] W_NONE = 2'b00;
    localparam logic [1:0] W_P0   = 2'b01;
    localparam logic [1:0] W_P1   = 2'b10;
    localparam logic [1:0] W_TIE  = 2'b11;

    // Value of card idx from the packed card vector.
    function automatic logic [3:0] card_val(input logic [63:0] cards, input logic [3:0] idx);
        return cards[{idx, 2'b00} +: 4];
    endfunction

    // Winner code from the two final scores.
    function automatic logic [1:0] winner_of(input logic [3:0] s0, input logic [3:0] s1);
        if (s0 > s1)      return W_P0;
        else if (s1 > s0) return W_P1;
        else              return W_TIE;
    endfunction

endpackage

// File: rtl/turn_timer.sv
// Loadable down counter; expired is high in the last enabled cycle of a load.
module turn_timer #(
    parameter int unsigned CYCLES = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic load,
    input  logic en,
    output logic expired
);

    localparam int unsigned W = $clog2(CYCLES + 1);
    localparam logic [W-1:0] LOAD_VAL = W'(CYCLES);
    localparam logic [W-1:0] ONE      = W'(1);

    logic [W-1:0] cnt;

    // Count down while enabled; a load always takes priority.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)                     cnt <= '0;
        else if (load)               cnt <= LOAD_VAL;
        else if (en && cnt != '0)    cnt <= cnt - ONE;
    end

    // Not gated by load: the FSM derives load from expired, so gating would close a loop.
    assign expired = en && (cnt == ONE);

endmodule

// File: rtl/memory_turn_ctrl.sv
// Two-player turn sequencer for the 16-card memory game.
module memory_turn_ctrl #(
    parameter int unsigned TURN_CYCLES = 500_000_000,
    parameter int unsigned SHOW_CYCLES = 50_000_000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        sel_valid,
    input  logic [3:0]  sel_idx,
    input  logic [63:0] cards,
    output logic        player,
    output logic [15:0] face_up,
    output logic [15:0] matched,
    output logic [3:0]  score0,
    output logic [3:0]  score1,
    output logic        sel_err,
    output logic        timeout,
    output logic        game_over,
    output logic [1:0]  winner,
    output logic [3:0]  state
);

    import memgame_pkg::*;

    state_t                 state_q, state_d;
    logic                   player_q, player_d;
    logic [NUM_CARDS-1:0]   face_q, face_d, match_q, match_d;
    logic [3:0]             s0_q, s0_d, s1_q, s1_d;
    logic [3:0]             left_q, left_d;
    logic [3:0]             first_q, first_d, second_q, second_d;
    logic                   hit_q, hit_d;
    logic                   err_q, err_d, to_q, to_d;
    logic                   go_q, go_d;
    logic [1:0]             win_q, win_d;

    logic                   turn_load, turn_en, turn_exp;
    logic                   show_load, show_en, show_exp;
    logic                   in_turn, accept1, accept2, cmp_hit;
    logic [NUM_CARDS-1:0]   sel_bit, pair_bits;

    assign in_turn   = (state_q == FIRST) || (state_q == SECOND);
    assign sel_bit   = 16'd1 << sel_idx;
    assign pair_bits = (16'd1 << first_q) | (16'd1 << second_q);
    assign accept1   = (state_q == FIRST) && sel_valid && !match_q[sel_idx] && !face_q[sel_idx];
    assign accept2   = (state_q == SECOND) && sel_valid && (sel_idx != first_q) && !match_q[sel_idx];
    assign cmp_hit   = card_val(cards, first_q) == card_val(cards, second_q);
    assign turn_en   = in_turn;
    assign show_en   = (state_q == SHOW);

    turn_timer #(.CYCLES(TURN_CYCLES)) u_turn_timer (
        .clk     (clk),
        .rst     (rst),
        .load    (turn_load),
        .en      (turn_en),
        .expired (turn_exp)
    );

    turn_timer #(.CYCLES(SHOW_CYCLES)) u_show_timer (
        .clk     (clk),
        .rst     (rst),
        .load    (show_load),
        .en      (show_en),
        .expired (show_exp)
    );

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    // Next-state logic; an accepted selection beats a same-cycle timer expiry.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE, DONE: if (start) state_d = FIRST;
            FIRST: begin
                if (accept1)       state_d = SECOND;
                else if (turn_exp) state_d = FIRST;
            end
            SECOND: begin
                if (accept2)       state_d = COMPARE;
                else if (turn_exp) state_d = FIRST;
            end
            COMPARE: state_d = SHOW;
            SHOW: begin
                if (show_exp) state_d = (hit_q && left_q == '0) ? DONE : FIRST;
            end
            default: state_d = IDLE;
        endcase
    end

    // Next values of the registered outputs and datapath, plus timer loads.
    always_comb begin
        player_d  = player_q;
        face_d    = face_q;
        match_d   = match_q;
        s0_d      = s0_q;
        s1_d      = s1_q;
        left_d    = left_q;
        first_d   = first_q;
        second_d  = second_q;
        hit_d     = hit_q;
        err_d     = in_turn && sel_valid && !accept1 && !accept2;
        to_d      = 1'b0;
        turn_load = 1'b0;
        show_load = 1'b0;
        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    player_d  = 1'b0;
                    face_d    = '0;
                    match_d   = '0;
                    s0_d      = '0;
                    s1_d      = '0;
                    left_d    = 4'(NUM_PAIRS);
                    hit_d     = 1'b0;
                    turn_load = 1'b1;
                end
            end
            FIRST, SECOND: begin
                if (accept1 || accept2) begin
                    face_d    = face_q | sel_bit;
                    turn_load = 1'b1;
                    if (accept1) first_d  = sel_idx;
                    else         second_d = sel_idx;
                end else if (turn_exp) begin
                    to_d      = 1'b1;
                    face_d    = '0;
                    player_d  = ~player_q;
                    turn_load = 1'b1;
                end
            end
            COMPARE: begin
                hit_d     = cmp_hit;
                show_load = 1'b1;
                if (cmp_hit) begin
                    match_d = match_q | pair_bits;
                    face_d  = face_q & ~pair_bits;
                    left_d  = left_q - 4'd1;
                    if (player_q) s1_d = s1_q + 4'd1;
                    else          s0_d = s0_q + 4'd1;
                end
            end
            SHOW: begin
                if (show_exp) begin
                    if (!hit_q) begin
                        face_d    = face_q & ~pair_bits;
                        player_d  = ~player_q;
                        turn_load = 1'b1;
                    end else if (left_q != '0) begin
                        turn_load = 1'b1;
                    end
                end
            end
            default: ;
        endcase
        go_d  = (state_d == DONE);
        win_d = go_d ? winner_of(s0_d, s1_d) : W_NONE;
    end

    // Datapath and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            player_q <= 1'b0;
            face_q   <= '0;
            match_q  <= '0;
            s0_q     <= '0;
            s1_q     <= '0;
            left_q   <= '0;
            first_q  <= '0;
            second_q <= '0;
            hit_q    <= 1'b0;
            err_q    <= 1'b0;
            to_q     <= 1'b0;
            go_q     <= 1'b0;
            win_q    <= W_NONE;
        end else begin
            player_q <= player_d;
            face_q   <= face_d;
            match_q  <= match_d;
            s0_q     <= s0_d;
            s1_q     <= s1_d;
            left_q   <= left_d;
            first_q  <= first_d;
            second_q <= second_d;
            hit_q    <= hit_d;
            err_q    <= err_d;
            to_q     <= to_d;
            go_q     <= go_d;
            win_q    <= win_d;
        end
    end

    assign player    = player_q;
    assign face_up   = face_q;
    assign matched   = match_q;
    assign score0    = s0_q;
    assign score1    = s1_q;
    assign sel_err   = err_q;
    assign timeout   = to_q;
    assign game_over = go_q;
    assign winner    = win_q;
    assign state     = state_q;

endmodule

// File: tb/tb_memory_turn_ctrl.sv
// Scoreboard bench for memory_turn_ctrl with short turn/show timers.
module tb_memory_turn_ctrl;

    logic        clk = 1'b0;
    logic        rst, start, sel_valid;
    logic [3:0]  sel_idx;
    logic [63:0] cards;
    logic        player, sel_err, timeout, game_over;
    logic [15:0] face_up, matched;
    logic [3:0]  score0, score1, state;
    logic [1:0]  winner;

    always #5 clk = ~clk;

    memory_turn_ctrl #(.TURN_CYCLES(20), .SHOW_CYCLES(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .sel_valid (sel_valid),
        .sel_idx   (sel_idx),
        .cards     (cards),
        .player    (player),
        .face_up   (face_up),
        .matched   (matched),
        .score0    (score0),
        .score1    (score1),
        .sel_err   (sel_err),
        .timeout   (timeout),
        .game_over (game_over),
        .winner    (winner),
        .state     (state)
    );

    typedef struct {
        string       tag;
        logic [3:0]  st;
        logic        ply;
        logic [15:0] fu;
        logic [15:0] mt;
        logic [3:0]  s0;
        logic [3:0]  s1;
        logic        err;
        logic        to;
        logic        go;
        logic [1:0]  win;
    } snap_t;

    snap_t sb[$];
    int    n_cmp = 0;
    int    n_bad = 0;

    // Game-level reference model.
    logic        m_player;
    logic [15:0] m_face, m_matched;
    logic [3:0]  m_s0, m_s1, m_left;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, want %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic model_reset();
        m_player  = 1'b0;
        m_face    = '0;
        m_matched = '0;
        m_s0      = '0;
        m_s1      = '0;
        m_left    = 4'd8;
    endtask

    task automatic push_exp(input string tag, input logic [3:0] st, input logic err, input logic to);
        snap_t e;
        e.tag = tag;
        e.st  = st;
        e.ply = m_player;
        e.fu  = m_face;
        e.mt  = m_matched;
        e.s0  = m_s0;
        e.s1  = m_s1;
        e.err = err;
        e.to  = to;
        e.go  = (st == 4'd5);
        if (st != 4'd5)       e.win = 2'b00;
        else if (m_s0 > m_s1) e.win = 2'b01;
        else if (m_s1 > m_s0) e.win = 2'b10;
        else                  e.win = 2'b11;
        sb.push_back(e);
    endtask

    task automatic check_snap();
        snap_t e;
        if (sb.size() == 0) begin
            chk("scoreboard_empty", 32'd1, 32'd0);
            return;
        end
        e = sb.pop_front();
        chk({e.tag, ".state"},     state,     e.st);
        chk({e.tag, ".player"},    player,    e.ply);
        chk({e.tag, ".face_up"},   face_up,   e.fu);
        chk({e.tag, ".matched"},   matched,   e.mt);
        chk({e.tag, ".score0"},    score0,    e.s0);
        chk({e.tag, ".score1"},    score1,    e.s1);
        chk({e.tag, ".sel_err"},   sel_err,   e.err);
        chk({e.tag, ".timeout"},   timeout,   e.to);
        chk({e.tag, ".game_over"}, game_over, e.go);
        chk({e.tag, ".winner"},    winner,    e.win);
    endtask

    task automatic pick(input logic [3:0] i);
        sel_idx   = i;
        sel_valid = 1'b1;
        tick();
        sel_valid = 1'b0;
    endtask

    task automatic bad_pick(input string tag, input logic [3:0] i, input logic [3:0] st, input logic [15:0] fu);
        pick(i);
        chk({tag, ".sel_err"}, sel_err, 1'b1);
        chk({tag, ".state"},   state,   st);
        chk({tag, ".face_up"}, face_up, fu);
    endtask

    task automatic start_game(input string tag);
        start = 1'b1;
        tick();
        start = 1'b0;
        model_reset();
        push_exp(tag, 4'd1, 1'b0, 1'b0);
        check_snap();
    endtask

    // First card already picked; pick b, then follow compare and show.
    task automatic finish_turn(input string tag, input logic [3:0] a, input logic [3:0] b);
        logic [15:0] bits;
        logic        hit;
        pick(b);
        chk({tag, ".cmp_state"},   state,   4'd3);
        chk({tag, ".cmp_timeout"}, timeout, 1'b0);
        bits = (16'd1 << a) | (16'd1 << b);
        hit  = (a[2:0] == b[2:0]);
        if (hit) begin
            m_matched = m_matched | bits;
            m_face    = '0;
            m_left    = m_left - 4'd1;
            if (m_player) m_s1 = m_s1 + 4'd1;
            else          m_s0 = m_s0 + 4'd1;
        end else begin
            m_face = bits;
        end
        push_exp({tag, ".show"}, 4'd4, 1'b0, 1'b0);
        if (!hit) begin
            m_face   = '0;
            m_player = ~m_player;
        end
        push_exp({tag, ".end"}, (hit && m_left == 4'd0) ? 4'd5 : 4'd1, 1'b0, 1'b0);
        tick();
        check_snap();
        repeat (3) tick();
        chk({tag, ".dwell_state"}, state,   4'd4);
        chk({tag, ".dwell_face"},  face_up, hit ? 16'h0000 : bits);
        tick();
        check_snap();
    endtask

    task automatic do_turn(input string tag, input logic [3:0] a, input logic [3:0] b, input int gap);
        pick(a);
        repeat (gap) tick();
        finish_turn(tag, a, b);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: run still active at %0t, required completion", $time);
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst       = 1'b1;
        start     = 1'b0;
        sel_valid = 1'b0;
        sel_idx   = '0;
        for (int j = 0; j < 16; j++) cards[4*j +: 4] = 4'(j % 8);
        model_reset();
        #12;
        push_exp("reset", 4'd0, 1'b0, 1'b0);
        check_snap();
        rst = 1'b0;
        tick();

        // Game 1: ends 5/3.
        start_game("start1");
        do_turn("match", 4'd0, 4'd8, 0);
        do_turn("miss",  4'd1, 4'd2, 0);

        bad_pick("first_matched", 4'd0, 4'd1, 16'h0000);
        pick(4'd1);
        bad_pick("second_same",    4'd1, 4'd2, 16'h0002);
        bad_pick("second_matched", 4'd8, 4'd2, 16'h0002);
        finish_turn("p1_hit", 4'd1, 4'd9);

        pick(4'd2);
        repeat (19) tick();
        chk("pre_timeout.timeout", timeout, 1'b0);
        chk("pre_timeout.state",   state,   4'd2);
        m_face   = '0;
        m_player = ~m_player;
        push_exp("timeout", 4'd1, 1'b0, 1'b1);
        tick();
        check_snap();
        tick();
        chk("timeout_pulse_end", timeout, 1'b0);

        do_turn("coincide", 4'd3, 4'd11, 19);
        do_turn("p0_a",  4'd2, 4'd10, 0);
        do_turn("p0_ms", 4'd4, 4'd5,  0);
        do_turn("p1_a",  4'd5, 4'd13, 0);
        do_turn("p1_b",  4'd6, 4'd14, 0);
        do_turn("p1_ms", 4'd4, 4'd7,  0);
        do_turn("p0_b",  4'd4, 4'd12, 0);
        do_turn("p0_c",  4'd7, 4'd15, 0);

        pick(4'd3);
        push_exp("done_sel", 4'd5, 1'b0, 1'b0);
        check_snap();

        // Game 2: ends 4/4.
        start_game("start2");
        do_turn("t0", 4'd0, 4'd8,  0);
        do_turn("t1", 4'd1, 4'd9,  0);
        do_turn("t2", 4'd2, 4'd10, 0);
        do_turn("t3", 4'd3, 4'd11, 0);
        do_turn("t4", 4'd4, 4'd5,  0);
        do_turn("t5", 4'd4, 4'd12, 0);
        do_turn("t6", 4'd5, 4'd13, 0);
        do_turn("t7", 4'd6, 4'd14, 0);
        do_turn("t8", 4'd7, 4'd15, 0);

        // Game 3: reset while in SHOW, checked before any clock edge.
        start_game("start3");
        pick(4'd0);
        pick(4'd8);
        tick();
        chk("pre_rst.state", state, 4'd4);
        #1;
        rst = 1'b1;
        #1;
        model_reset();
        push_exp("rst_show", 4'd0, 1'b0, 1'b0);
        check_snap();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
